relu_backward: RTL

RELU_BACKWARD -- requirements
Module: relu_backward

---
 rtl/relu_backward.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/relu_backward.sv
// ---------------------------------------------------------------------------
// relu_backward
//
// Backward pass of a vector ReLU. Each forward pre-activation vector is turned
// into a one-bit-per-element "was positive" mask and queued in a small FIFO.
// Each incoming upstream gradient pops the oldest mask and is gated by it:
// elements whose forward input was strictly positive pass through unchanged,
// the rest are zeroed. The gated result sits in a one-deep output register
// with valid/ready flow control, so one vector per cycle can stream through.
//
// Optional feature (compile-time macro RELU_BWD_LEAKY_EN):
//   When defined, masked elements become grad_in >>> 3 (leaky slope 1/8,
//   arithmetic shift, rounds toward negative infinity) instead of zero.
//
// Parameters
//   VEC_SIZE    elements per vector
//   DATA_WIDTH  signed two's-complement element width
//   FIXED_PNT   fractional bits; format bookkeeping only
//   MASK_DEPTH  number of forward masks that can be queued (>= 1, any value)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   flush       synchronous discard of every queued mask
//   fwd_valid / fwd_ready / fwd_vec     forward pre-activation channel
//   grad_valid / grad_ready / grad_in   upstream gradient channel
//   out_valid / out_ready / grad_out    gated gradient channel
//   mask_count  number of masks currently queued
// ---------------------------------------------------------------------------
module relu_backward #(
    parameter int VEC_SIZE   = 64,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int MASK_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,

    input  logic                                   fwd_valid,
    output logic                                   fwd_ready,
    input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]    fwd_vec,

    input  logic                                   grad_valid,
    output logic                                   grad_ready,
    input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]    grad_in,

    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]    grad_out,

    output logic [$clog2(MASK_DEPTH+1)-1:0]        mask_count
);

    localparam int CNT_W = $clog2(MASK_DEPTH + 1);
    // A single-entry FIFO still needs a one-bit pointer to stay legal.
    localparam int PTR_W = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;

    // Reject configurations that cannot be built meaningfully.
    generate
        if (MASK_DEPTH < 1 || FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_cfg
            $error("relu_backward: MASK_DEPTH must be >= 1 and FIXED_PNT in [0, DATA_WIDTH)");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic [VEC_SIZE-1:0]                 mask_mem [MASK_DEPTH];
    logic [PTR_W-1:0]                    wr_ptr;
    logic [PTR_W-1:0]                    rd_ptr;

    logic                                fwd_fire;
    logic                                grad_fire;
    logic [VEC_SIZE-1:0]                 fwd_mask;
    logic [VEC_SIZE-1:0]                 pop_mask;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] gated;

    // Pointer advance with explicit wrap, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(MASK_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    // Both readies are forced low while reset is asserted and while flushing,
    // which also guarantees no transfer is counted in those cycles. There is
    // no full-FIFO bypass: a push only looks at the current occupancy.
    assign fwd_ready  = rst_n && !flush && (mask_count < CNT_W'(MASK_DEPTH));

    // A gradient needs a stored mask and room in the output register (either
    // empty or being drained this very cycle). A mask pushed this cycle is not
    // yet counted, so it becomes poppable one cycle later.
    assign grad_ready = rst_n && !flush && (mask_count != '0) &&
                        (!out_valid || out_ready);

    assign fwd_fire  = fwd_valid  && fwd_ready;
    assign grad_fire = grad_valid && grad_ready;

    // -----------------------------------------------------------------------
    // Mask generation and gating
    // -----------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a value on every path
    // (here by the loop covering all elements and both branches), otherwise
    // synthesis infers a latch to hold the old value.
    always_comb begin
        for (int i = 0; i < VEC_SIZE; i++) begin
            // Strictly positive: sign bit clear and not zero.
            fwd_mask[i] = !fwd_vec[i][DATA_WIDTH-1] && (fwd_vec[i] != '0);
        end
    end

    always_comb begin
        pop_mask = mask_mem[rd_ptr];
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (pop_mask[i]) begin
                gated[i] = grad_in[i];
            end else begin
`ifdef RELU_BWD_LEAKY_EN
                // Arithmetic shift floors toward negative infinity.
                gated[i] = DATA_WIDTH'($signed(grad_in[i]) >>> 3);
`else
                gated[i] = '0;
`endif
            end
        end
    end

    // -----------------------------------------------------------------------
    // Mask FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset. Validity is tracked
    // by mask_count and the pointers, which are reset, so stale contents are
    // never observed; leaving the array unreset keeps it mappable to plain
    // memory without a reset fan-out to every bit.
    always_ff @(posedge clk) begin
        if (fwd_fire) begin
            mask_mem[wr_ptr] <= fwd_mask;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    // NOTE: clocked state is always assigned with non-blocking (<=) so every
    // register samples the pre-edge value of its inputs regardless of the
    // order of statements or always blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else if (flush) begin
            // Any push or pop attempted this cycle is dropped (readies are low).
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else begin
            if (fwd_fire) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (grad_fire) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({fwd_fire, grad_fire})
                2'b10:   mask_count <= mask_count + CNT_W'(1);
                2'b01:   mask_count <= mask_count - CNT_W'(1);
                default: mask_count <= mask_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    // Flush does not touch this register: an already computed result is still
    // delivered. A new load takes precedence over draining so a consumer with
    // out_ready held high sees one vector per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            grad_out  <= '0;
        end else if (grad_fire) begin
            out_valid <= 1'b1;
            grad_out  <= gated;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
